// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite ROM in raster order, with
// optional mirroring, and emits one screen pixel per clock. Pixels whose
// colour matches the key or that land off-screen are suppressed but still
// take their slot, so draw time depends only on the sprite size.
module sprite_blitter #(
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 32,
    parameter int COORD_W  = 10,
    parameter int ADDR_W   = 10,
    parameter int COLOR_W  = 3,
    parameter int ROM_LAT  = 1,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               flip_x,
    input  logic               flip_y,
    input  logic               key_en,
    input  logic [COLOR_W-1:0] key_color,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               plot_out,
    output logic [COORD_W-1:0] x_pix,
    output logic [COORD_W-1:0] y_pix,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               draw_done
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int XW = COORD_W + 1;
    localparam logic [CW-1:0] LAST_COL   = CW'(SPR_W - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(SPR_H - 1);
    localparam logic [XW-1:0] X_LIMIT    = XW'(SCREEN_W);
    localparam logic [XW-1:0] Y_LIMIT    = XW'(SCREEN_H);
    localparam logic [1:0]    DRAIN_LAST = 2'(ROM_LAT);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic               lastPix;
    logic [1:0]         drain_q;

    logic [COORD_W-1:0] xBase_q, yBase_q;
    logic               xFlip_q, yFlip_q, keyEn_q;
    logic [COLOR_W-1:0] keyColor_q;
    logic [ADDR_W-1:0]  romAddr_q;

    logic [ROM_LAT-1:0]         pValid_q;
    logic [ROM_LAT-1:0][CW-1:0] pCol_q;
    logic [ROM_LAT-1:0][RW-1:0] pRow_q;

    logic [XW-1:0]      xSum, ySum;
    logic               pixVisible;

    logic               plot_q;
    logic [COORD_W-1:0] xPix_q, yPix_q;
    logic [COLOR_W-1:0] color_q;

    // Source ROM address for a destination (col,row), applying mirroring.
    function automatic logic [ADDR_W-1:0] srcAddr(input logic [CW-1:0] c,
                                                  input logic [RW-1:0] r,
                                                  input logic fx,
                                                  input logic fy);
        int sc;
        int sr;
        sc = fx ? (SPR_W - 1 - int'(c)) : int'(c);
        sr = fy ? (SPR_H - 1 - int'(r)) : int'(r);
        return ADDR_W'(sr * SPR_W + sc);
    endfunction

    // Raster walk: next column/row and detection of the final pixel.
    always_comb begin
        col_d   = col_q + 1'b1;
        row_d   = row_q;
        lastPix = (col_q == LAST_COL) && (row_q == LAST_ROW);
        if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end
    end

    // Next-state logic plus the status outputs that depend only on state.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        draw_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (lastPix) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == DRAIN_LAST) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                draw_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Accept a draw: latch parameters, then present one ROM address per clock.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            xBase_q    <= '0;
            yBase_q    <= '0;
            xFlip_q    <= 1'b0;
            yFlip_q    <= 1'b0;
            keyEn_q    <= 1'b0;
            keyColor_q <= '0;
            romAddr_q  <= '0;
        end else begin
            drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : 2'd0;
            if (state_q == IDLE && start) begin
                xBase_q    <= x_pos;
                yBase_q    <= y_pos;
                xFlip_q    <= flip_x;
                yFlip_q    <= flip_y;
                keyEn_q    <= key_en;
                keyColor_q <= key_color;
                col_q      <= '0;
                row_q      <= '0;
                romAddr_q  <= srcAddr('0, '0, flip_x, flip_y);
            end else if (state_q == FETCH && !lastPix) begin
                col_q     <= col_d;
                row_q     <= row_d;
                romAddr_q <= srcAddr(col_d, row_d, xFlip_q, yFlip_q);
            end
        end
    end

    // Carry each pixel's destination position alongside the ROM read latency.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            pValid_q <= '0;
            pCol_q   <= '0;
            pRow_q   <= '0;
        end else begin
            pValid_q[0] <= (state_q == FETCH);
            pCol_q[0]   <= col_q;
            pRow_q[0]   <= row_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                pValid_q[i] <= pValid_q[i-1];
                pCol_q[i]   <= pCol_q[i-1];
                pRow_q[i]   <= pRow_q[i-1];
            end
        end
    end

    assign xSum = XW'(xBase_q) + XW'(pCol_q[ROM_LAT-1]);
    assign ySum = XW'(yBase_q) + XW'(pRow_q[ROM_LAT-1]);
    assign pixVisible = pValid_q[ROM_LAT-1]
                      && !(keyEn_q && (rom_data == keyColor_q))
                      && !xSum[COORD_W] && (xSum < X_LIMIT)
                      && !ySum[COORD_W] && (ySum < Y_LIMIT);

    // Output stage: load a pixel only when it is drawn, otherwise hold.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            plot_q  <= 1'b0;
            xPix_q  <= '0;
            yPix_q  <= '0;
            color_q <= '0;
        end else begin
            plot_q <= pixVisible;
            if (pixVisible) begin
                xPix_q  <= xSum[COORD_W-1:0];
                yPix_q  <= ySum[COORD_W-1:0];
                color_q <= rom_data;
            end
        end
    end

    assign rom_addr = romAddr_q;
    assign plot_out = plot_q;
    assign x_pix    = xPix_q;
    assign y_pix    = yPix_q;
    assign color    = color_q;

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- SPR_W, 32, sprite width in pixels (>=1).
- SPR_H, 32, sprite height in pixels (>=1).
- COORD_W, 10, screen coordinate width.
- ADDR_W, 10, sprite ROM address width (2^ADDR_W >= SPR_W*SPR_H).
- COLOR_W, 3, pixel colour width.
- ROM_LAT, 1, sprite ROM read latency in clocks (1..3).
- SCREEN_W, 640, visible width; columns >= SCREEN_W are clipped.
- SCREEN_H, 480, visible height; rows >= SCREEN_H are clipped.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, clock.
- reset_n, in, 1, asynchronous active-high reset.
- start, in, 1, draw request.
- x_pos, in, COORD_W, sprite top-left x.
- y_pos, in, COORD_W, sprite top-left y.
- flip_x, in, 1, mirror horizontally.
- flip_y, in, 1, mirror vertically.
- key_en, in, 1, colour-key transparency enable.
- key_color, in, COLOR_W, transparent colour.
- rom_data, in, COLOR_W, ROM pixel data.
- rom_addr, out, ADDR_W, ROM read address.
- plot_out, out, 1, write strobe for x_pix/y_pix/color.
- x_pix, out, COORD_W, pixel x.
- y_pix, out, COORD_W, pixel y.
- color, out, COLOR_W, pixel colour.
- busy, out, 1, draw in progress.
- draw_done, out, 1, one-cycle completion pulse.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, FETCH, DRAIN, DONE.
REQ-005 Transitions SHALL be:
- IDLE->FETCH when start=1.
- FETCH->DRAIN after the last address is issued.
- DRAIN->DONE after ROM_LAT cycles.
- DONE->IDLE unconditionally.
REQ-006 start SHALL be accepted only in IDLE; start in any other state, including DONE, SHALL be ignored.
REQ-007 On acceptance the block SHALL latch x_pos, y_pos, flip_x, flip_y, key_en and key_color; input changes during a draw SHALL have no effect.
REQ-008 FETCH SHALL issue one registered rom_addr per clock, in raster order (col 0..SPR_W-1 within row 0..SPR_H-1), N=SPR_W*SPR_H addresses in total.
REQ-009 rom_addr SHALL equal src_row*SPR_W+src_col, where:
- src_col = flip_x ? SPR_W-1-col : col.
- src_row = flip_y ? SPR_H-1-row : row.
REQ-010 The row/col counters SHALL travel through a ROM_LAT-deep pipeline alongside each address.
REQ-011 Output registers SHALL update one clock after rom_data is valid. Pixel i therefore appears ROM_LAT+1 cycles after its address.
REQ-012 For each pixel, the output registers SHALL load x_pix=x_pos+col, y_pix=y_pos+row and color=rom_data.
REQ-013 The x/y sums SHALL be computed at COORD_W+1 bits; any carry SHALL count as clipped.
REQ-014 plot_out SHALL be 1 for a pixel unless it is:
- transparent: key_en=1 and rom_data==key_color; or
- clipped: sum>=SCREEN_W or sum>=SCREEN_H, in the respective axis.
Suppressed pixels SHALL still consume their cycle.
REQ-015 busy SHALL be 1 in FETCH, DRAIN and DONE, and 0 in IDLE.
REQ-016 draw_done SHALL be 1 for exactly the DONE cycle, N+ROM_LAT+1 cycles after the accepting edge.
REQ-017 When plot_out=0, x_pix, y_pix and color SHALL hold their last values.

Reset
REQ-018 While reset_n=1, the FSM SHALL be in IDLE and all counters and pipeline valid bits SHALL be 0.
REQ-019 While reset_n=1, rom_addr, x_pix, y_pix, color, plot_out, busy and draw_done SHALL all be 0.
REQ-020 Reset asserted mid-draw SHALL abort the draw immediately, with no further plot_out or draw_done for that draw.
REQ-021 The first start after reset release SHALL begin at pixel 0.

Verification (SPR_W=4, SPR_H=2, ROM_LAT=1, rom_data=rom_addr[2:0] unless stated)
REQ-022 Basic draw: start at (10,20), no flip, key_en=0.
- rom_addr runs 0..7.
- 8 plots: (10..13,20), then (10..13,21).
- First plot 2 cycles after acceptance.
- draw_done 10 cycles after acceptance.
REQ-023 Flip: flip_x=1, flip_y=1, otherwise as REQ-022.
- rom_addr sequence is 7,6,5,4,3,2,1,0.
- First plot is (10,20) with color 7.
REQ-024 Transparency: key_en=1, key_color=0.
- Pixel (10,20) is not plotted; 7 plots.
- draw_done timing is unchanged at 10 cycles.
REQ-025 Clipping: x_pos=SCREEN_W-2, y_pos=SCREEN_H-1.
- Only (638,479) and (639,479) are plotted.
- Row 480 and x>=640 are suppressed; draw_done still occurs at 10 cycles.
REQ-026 Re-start and reset:
- start pulsed mid-draw and in the DONE cycle is ignored.
- reset_n asserted at the 4th plot forces all outputs to 0 at once, with no draw_done.
- The next start plots from rom_addr 0.
